// File: rtl/vec_vcfg_issue_pkg.sv
// Shared types and constants for the vector configuration (vsetvl*) issue unit.
package vec_vcfg_issue_pkg;

  typedef logic [2:0] vcfg_state_e;
  localparam vcfg_state_e ST_IDLE  = 3'd0;
  localparam vcfg_state_e ST_CALC  = 3'd1;
  localparam vcfg_state_e ST_WRITE = 3'd2;
  localparam vcfg_state_e ST_WAIT  = 3'd3;
  localparam vcfg_state_e ST_RESP  = 3'd4;

  localparam logic [6:0] OPC_VEC    = 7'b1010111;
  localparam logic [2:0] FUNCT3_CFG = 3'b111;

  typedef enum logic [2:0] {LMUL_1 = 3'd0, LMUL_2, LMUL_4, LMUL_8} vlmul_e;
  typedef enum logic [2:0] {EW8 = 3'd0, EW16, EW32, EW64} vew_e;

  typedef struct packed {
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } csr_vtype_s;

  typedef enum logic [1:0] {CFG_NONE, CFG_VSETVLI, CFG_VSETIVLI, CFG_VSETVL} cfg_kind_e;

  // inst[31:30]=2'b10 is only vsetvl when inst[29:25] are all zero.
  function automatic cfg_kind_e decode_cfg(input logic [31:0] inst);
    if (inst[6:0] != OPC_VEC || inst[14:12] != FUNCT3_CFG) return CFG_NONE;
    if (!inst[31]) return CFG_VSETVLI;
    if (inst[30]) return CFG_VSETIVLI;
    if (inst[29:25] == 5'b00000) return CFG_VSETVL;
    return CFG_NONE;
  endfunction

endpackage

// File: rtl/vec_vcfg_issue_if.sv
// Scalar-core issue/response channel of the vector configuration unit.
interface vec_vcfg_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [4:0]      rd_addr;
  logic            rd_we;
  logic [XLEN-1:0] rd_data;
  logic            vcfg_err;

  modport master (
    output inst_valid, inst, rs1_data, rs2_data, rd_ready,
    input  inst_ready, rd_valid, rd_addr, rd_we, rd_data, vcfg_err
  );

  modport slave (
    input  inst_valid, inst, rs1_data, rs2_data, rd_ready,
    output inst_ready, rd_valid, rd_addr, rd_we, rd_data, vcfg_err
  );
endinterface

// File: rtl/vec_vl_calc.sv
// Combinational vtype legality check, VLMAX and vl computation.
module vec_vl_calc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 512
) (
  input  logic [XLEN-1:0] vtype,
  input  logic [XLEN-1:0] avl,
  output logic [XLEN-1:0] vl,
  output logic            vtype_illegal
);
  logic [2:0]      vsew;
  logic [2:0]      vlmul;
  logic [XLEN-1:0] vlmax;

  always_comb begin
    vsew  = vtype[5:3];
    vlmul = vtype[2:0];
    // Only integer LMUL and SEW up to 64 are supported; anything above bit 7 is reserved.
    vtype_illegal = vsew[2] | vlmul[2] | ((vtype >> 8) != '0);
    vlmax = (XLEN'(VLEN) >> (3 + vsew[1:0])) << vlmul[1:0];
    vl    = (avl < vlmax) ? avl : vlmax;
  end
endmodule

// File: rtl/vec_vcfg_issue.sv
// Vector configuration CSR writer: executes vsetvli/vsetivli/vsetvl, writes vl/vtype, returns vl.
module vec_vcfg_issue
  import vec_vcfg_issue_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned VLEN         = 512,
  parameter int unsigned DONE_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  vec_vcfg_issue_if.slave issue,
  input  logic [XLEN-1:0] cur_vl,
  output logic            csrwr_en,
  output logic [XLEN-1:0] scalar1,
  output logic [XLEN-1:0] scalar2,
  input  logic            csr_done
);
  localparam int unsigned CW = $clog2(DONE_TIMEOUT + 1);

  vcfg_state_e     state;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] avl_q;
  logic [XLEN-1:0] vtype_q;
  logic            err_q;
  logic [CW-1:0]   cnt;

  cfg_kind_e       kind;
  logic [4:0]      f_rd;
  logic [4:0]      f_rs1;
  logic [XLEN-1:0] avl_d;
  logic [XLEN-1:0] vtype_d;
  logic            accept;
  logic [XLEN-1:0] calc_vl;
  logic            calc_illegal;

  assign issue.inst_ready = !rst && (state == ST_IDLE);

  always_comb begin
    kind    = decode_cfg(issue.inst[31:0]);
    f_rd    = issue.inst[11:7];
    f_rs1   = issue.inst[19:15];
    accept  = issue.inst_valid && issue.inst_ready && (kind != CFG_NONE);
    vtype_d = '0;
    avl_d   = '0;
    case (kind)
      CFG_VSETVLI:  vtype_d = XLEN'(issue.inst[30:20]);
      CFG_VSETIVLI: vtype_d = XLEN'(issue.inst[29:20]);
      CFG_VSETVL:   vtype_d = issue.rs2_data;
      default:      vtype_d = '0;
    endcase
    if (kind == CFG_VSETIVLI) avl_d = XLEN'(f_rs1);
    else if (f_rs1 != 5'd0)   avl_d = issue.rs1_data;
    else if (f_rd != 5'd0)    avl_d = '1;
    else                      avl_d = cur_vl;
  end

  vec_vl_calc #(
    .XLEN (XLEN),
    .VLEN (VLEN)
  ) u_vl_calc (
    .vtype         (vtype_q),
    .avl           (avl_q),
    .vl            (calc_vl),
    .vtype_illegal (calc_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      rd_q           <= '0;
      avl_q          <= '0;
      vtype_q        <= '0;
      err_q          <= 1'b0;
      cnt            <= '0;
      csrwr_en       <= 1'b0;
      scalar1        <= '0;
      scalar2        <= '0;
      issue.rd_valid <= 1'b0;
      issue.rd_addr  <= '0;
      issue.rd_we    <= 1'b0;
      issue.rd_data  <= '0;
      issue.vcfg_err <= 1'b0;
    end else begin
      csrwr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q    <= f_rd;
            avl_q   <= avl_d;
            vtype_q <= vtype_d;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          scalar1  <= calc_illegal ? '0 : calc_vl;
          scalar2  <= calc_illegal ? {1'b1, {(XLEN-1){1'b0}}} : {{(XLEN-8){1'b0}}, vtype_q[7:0]};
          err_q    <= calc_illegal;
          csrwr_en <= 1'b1;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // csr_done wins over a timeout landing in the same cycle.
          if (csr_done) begin
            issue.rd_valid <= 1'b1;
            issue.rd_addr  <= rd_q;
            issue.rd_we    <= (rd_q != 5'd0) && !err_q;
            issue.rd_data  <= err_q ? '0 : scalar1;
            issue.vcfg_err <= err_q;
            cnt            <= '0;
            state          <= ST_RESP;
          end else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
            issue.rd_valid <= 1'b1;
            issue.rd_addr  <= rd_q;
            issue.rd_we    <= 1'b0;
            issue.rd_data  <= '0;
            issue.vcfg_err <= 1'b1;
            cnt            <= '0;
            state          <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (issue.rd_ready) begin
            issue.rd_valid <= 1'b0;
            issue.rd_we    <= 1'b0;
            issue.rd_data  <= '0;
            issue.vcfg_err <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_vcfg_issue.sv
// Directed table-driven bench for vec_vcfg_issue plus timeout/backpressure/reset sequences.
module tb_vec_vcfg_issue;
  logic        clk;
  logic        rst;
  logic [31:0] cur_vl;
  logic        csrwr_en;
  logic [31:0] scalar1;
  logic [31:0] scalar2;
  logic        csr_done;

  int unsigned n_cmp;
  int unsigned n_bad;

  vec_vcfg_issue_if #(.XLEN(32)) issue ();

  vec_vcfg_issue #(
    .XLEN         (32),
    .VLEN         (512),
    .DONE_TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .cur_vl   (cur_vl),
    .csrwr_en (csrwr_en),
    .scalar1  (scalar1),
    .scalar2  (scalar2),
    .csr_done (csr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] cur_vl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] rdd;
    logic [4:0]  rda;
    logic        we;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] f_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [10:0] z);
    return {1'b0, z, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] f_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                             input logic [9:0] z);
    return {2'b11, z, uimm, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] f_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] cvl);
    @(negedge clk);
    issue.inst       = inst;
    issue.rs1_data   = r1;
    issue.rs2_data   = r2;
    cur_vl           = cvl;
    issue.inst_valid = 1'b1;
    #1;
  endtask

  // Accept edge closes cycle N; returns mid-cycle N+1 with sources scrambled.
  task automatic after_accept();
    @(negedge clk);
    issue.inst_valid = 1'b0;
    issue.rs1_data   = 32'hDEAD_BEEF;
    issue.rs2_data   = 32'hFFFF_FFFF;
    cur_vl           = 32'h55;
  endtask

  task automatic run_vec(input vec_t v);
    present(v.inst, v.rs1_data, v.rs2_data, v.cur_vl);
    chk({v.name, " inst_ready"}, 32'(issue.inst_ready), 32'd1);
    after_accept();
    chk({v.name, " N+1 csrwr_en"}, 32'(csrwr_en), 32'd0);
    chk({v.name, " N+1 inst_ready"}, 32'(issue.inst_ready), 32'd0);
    @(negedge clk);
    chk({v.name, " N+2 csrwr_en"}, 32'(csrwr_en), 32'd1);
    chk({v.name, " scalar1"}, scalar1, v.s1);
    chk({v.name, " scalar2"}, scalar2, v.s2);
    @(negedge clk);
    chk({v.name, " N+3 csrwr_en"}, 32'(csrwr_en), 32'd0);
    csr_done = 1'b1;
    @(negedge clk);
    csr_done = 1'b0;
    chk({v.name, " rd_valid"}, 32'(issue.rd_valid), 32'd1);
    chk({v.name, " rd_addr"}, 32'(issue.rd_addr), 32'(v.rda));
    chk({v.name, " rd_we"}, 32'(issue.rd_we), 32'(v.we));
    chk({v.name, " rd_data"}, issue.rd_data, v.rdd);
    chk({v.name, " vcfg_err"}, 32'(issue.vcfg_err), 32'(v.err));
    chk({v.name, " scalar1 hold"}, scalar1, v.s1);
    issue.rd_ready = 1'b1;
    @(negedge clk);
    issue.rd_ready = 1'b0;
    chk({v.name, " rd_valid clr"}, 32'(issue.rd_valid), 32'd0);
    chk({v.name, " vcfg_err clr"}, 32'(issue.vcfg_err), 32'd0);
    chk({v.name, " idle ready"}, 32'(issue.inst_ready), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    cur_vl = '0;
    csr_done = 1'b0;
    issue.inst_valid = 1'b0;
    issue.inst = '0;
    issue.rs1_data = '0;
    issue.rs2_data = '0;
    issue.rd_ready = 1'b0;

    vecs[0]  = '{"e32m1 avl100", f_vsetvli(5, 1, 11'h010), 100, 0, 0, 16, 32'h10, 16, 5, 1'b1, 1'b0};
    vecs[1]  = '{"ivli5 e8m4", f_vsetivli(2, 5, 10'h002), 0, 0, 0, 5, 32'h02, 5, 2, 1'b1, 1'b0};
    vecs[2]  = '{"x0 rd3 e16m8", f_vsetvli(3, 0, 11'h00B), 123, 0, 0, 256, 32'h0B, 256, 3, 1'b1, 1'b0};
    vecs[3]  = '{"x0 rd0 curvl", f_vsetvli(0, 0, 11'h00B), 123, 0, 7, 7, 32'h0B, 7, 0, 1'b0, 1'b0};
    vecs[4]  = '{"vsetvl frac", f_vsetvl(4, 1, 2), 50, 32'h05, 0, 0, 32'h8000_0000, 0, 4, 1'b0, 1'b1};
    vecs[5]  = '{"e8m8 max", f_vsetvli(7, 1, 11'h003), 1000, 0, 0, 512, 32'h03, 512, 7, 1'b1, 1'b0};
    vecs[6]  = '{"e64m1 eq", f_vsetvli(1, 1, 11'h018), 8, 0, 0, 8, 32'h18, 8, 1, 1'b1, 1'b0};
    vecs[7]  = '{"e64m1 below", f_vsetvli(1, 1, 11'h018), 7, 0, 0, 7, 32'h18, 7, 1, 1'b1, 1'b0};
    vecs[8]  = '{"vsetvl bit8", f_vsetvl(6, 1, 3), 20, 32'h100, 0, 0, 32'h8000_0000, 0, 6, 1'b0, 1'b1};
    vecs[9]  = '{"vsetvl vma vta", f_vsetvl(6, 1, 3), 20, 32'hD0, 0, 16, 32'hD0, 16, 6, 1'b1, 1'b0};
    vecs[10] = '{"sew reserved", f_vsetvli(8, 1, 11'h020), 20, 0, 0, 0, 32'h8000_0000, 0, 8, 1'b0, 1'b1};
    vecs[11] = '{"unsigned avl", f_vsetvli(9, 2, 11'h000), 32'h8000_0000, 0, 0, 64, 32'h00, 64, 9, 1'b1, 1'b0};
    vecs[12] = '{"zimm bit10", f_vsetvli(9, 2, 11'h410), 5, 0, 0, 0, 32'h8000_0000, 0, 9, 1'b0, 1'b1};

    // Reset values
    @(negedge clk);
    chk("rst inst_ready", 32'(issue.inst_ready), 32'd0);
    chk("rst csrwr_en", 32'(csrwr_en), 32'd0);
    chk("rst scalar1", scalar1, 32'd0);
    chk("rst scalar2", scalar2, 32'd0);
    chk("rst rd_valid", 32'(issue.rd_valid), 32'd0);
    chk("rst rd_we", 32'(issue.rd_we), 32'd0);
    chk("rst rd_data", issue.rd_data, 32'd0);
    chk("rst vcfg_err", 32'(issue.vcfg_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst inst_ready", 32'(issue.inst_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Non-vcfg words are not accepted
    present(32'h0020_80B3, 1, 2, 0);
    @(negedge clk);
    issue.inst = {7'b1000001, 5'd2, 5'd1, 3'b111, 5'd4, 7'b1010111};
    #1;
    @(negedge clk);
    issue.inst_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nonvcfg inst_ready", 32'(issue.inst_ready), 32'd1);
      chk("nonvcfg csrwr_en", 32'(csrwr_en), 32'd0);
      @(negedge clk);
    end

    // Timeout: csr_done only during WRITE (ignored), then withheld for 8 WAIT cycles
    present(vecs[0].inst, 100, 0, 0);
    after_accept();
    @(negedge clk);
    chk("to N+2 csrwr_en", 32'(csrwr_en), 32'd1);
    csr_done = 1'b1;
    @(negedge clk);
    csr_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to wait rd_valid", 32'(issue.rd_valid), 32'd0);
      @(negedge clk);
    end
    chk("to rd_valid", 32'(issue.rd_valid), 32'd1);
    chk("to vcfg_err", 32'(issue.vcfg_err), 32'd1);
    chk("to rd_data", issue.rd_data, 32'd0);
    chk("to rd_we", 32'(issue.rd_we), 32'd0);
    chk("to scalar1 hold", scalar1, 32'd16);
    issue.rd_ready = 1'b1;
    @(negedge clk);
    issue.rd_ready = 1'b0;
    chk("to rd_valid clr", 32'(issue.rd_valid), 32'd0);

    // rd_ready held low for 5 cycles: response stable, unit busy
    present(vecs[2].inst, 0, 0, 0);
    after_accept();
    repeat (2) @(negedge clk);
    csr_done = 1'b1;
    @(negedge clk);
    csr_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold rd_valid", 32'(issue.rd_valid), 32'd1);
      chk("hold rd_addr", 32'(issue.rd_addr), 32'd3);
      chk("hold rd_data", issue.rd_data, 32'd256);
      chk("hold rd_we", 32'(issue.rd_we), 32'd1);
      chk("hold inst_ready", 32'(issue.inst_ready), 32'd0);
      @(negedge clk);
    end
    issue.rd_ready = 1'b1;
    @(negedge clk);
    issue.rd_ready = 1'b0;
    chk("hold rd_valid clr", 32'(issue.rd_valid), 32'd0);

    // rd_ready high throughout: ignored before RESP, completes in first RESP cycle
    issue.rd_ready = 1'b1;
    present(vecs[1].inst, 0, 0, 0);
    after_accept();
    repeat (2) @(negedge clk);
    csr_done = 1'b1;
    @(negedge clk);
    csr_done = 1'b0;
    chk("early rdy rd_valid", 32'(issue.rd_valid), 32'd1);
    chk("early rdy rd_data", issue.rd_data, 32'd5);
    @(negedge clk);
    issue.rd_ready = 1'b0;
    chk("early rdy done", 32'(issue.rd_valid), 32'd0);
    chk("early rdy idle", 32'(issue.inst_ready), 32'd1);

    // Reset in WAIT: back to IDLE, no response
    present(vecs[0].inst, 100, 0, 0);
    after_accept();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait scalar1", scalar1, 32'd0);
    csr_done = 1'b1;
    @(negedge clk);
    csr_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstwait rd_valid", 32'(issue.rd_valid), 32'd0);
      chk("rstwait inst_ready", 32'(issue.inst_ready), 32'd1);
      @(negedge clk);
    end

    // Reset in CALC: no CSR write strobe
    present(vecs[0].inst, 100, 0, 0);
    after_accept();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstcalc csrwr_en", 32'(csrwr_en), 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
